wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Two-master arbiter and slave decoder for the peripheral Wishbone bus (UART, timer).
//  M0 is the CPU data port; M1 is a secondary master (debug/DMA).
//  Grants the bus round-robin, holds the grant for a whole CYC, decodes ADR to the slave
//  strobes and routes ACK/DAT back. Unmapped addresses return ERR.
// PARAMETERS
//  AW       5   word-address width (ADR[6:2])
//  DW       8   data width
//  TIMEOUT  15  cycles STB may wait for ACK before ERR (only with WB_TIMEOUT_EN)
// PORTS
//  PClk            in   1   bus clock, rising edge
//  Reset           in   1   asynchronous, active-high
//  M0_CYC/M1_CYC   in   1   master cycle request; held for the whole transfer
//  M0_STB/M1_STB   in   1   master strobe
//  M0_WE/M1_WE     in   1   write enable
//  M0_ADR/M1_ADR   in   AW  word address
//  M0_DATW/M1_DATW in   DW  write data
//  M0_ACK/M1_ACK   out  1   transfer done
//  M0_ERR/M1_ERR   out  1   unmapped address or timeout; one cycle
//  M0_DATR/M1_DATR out  DW  read data (slave data muxed by the decoded slave)
//  M0_GNT/M1_GNT   out  1   current owner of the bus
//  ADR             out  AW  shared slave address (owner's ADR; 0 when idle)
//  DAT             out  DW  shared slave write data
//  WE              out  1   shared slave write enable (0 when idle)
//  STB_UART        out  1   UART strobe
//  STB_TMR         out  1   timer strobe
//  ACK_UART        in   1   UART ack
//  ACK_TMR         in   1   timer ack
//  DAT_UART        in   DW  UART read data
//  DAT_TMR         in   DW  timer read data
// BEHAVIOUR
//  Reset: state=IDLE, GNT=0, all STB/ACK/ERR=0, ADR/DAT/WE=0, last=M1 (M0 wins first tie).
//  FSM (registered): IDLE -> OWN0 | OWN1 -> IDLE.
//   IDLE: if exactly one CYC is high, grant it. If both are high, grant !last.
//    The grant takes effect next cycle (1-cycle arbitration latency).
//   OWNx: GNTx=1; last<=x. Hold while Mx_CYC=1; the other master waits (its ACK/ERR=0).
//    Mx_CYC=0 -> IDLE. There is always one IDLE cycle between owners (turnaround).
//  Decode (combinational from the owner's ADR):
//   00xxx=UART
//   01xxx,10xxx=TMR
//   11xxx=unmapped
//  Strobes: STB_slave = OWNx & Mx_CYC & Mx_STB & hit.
//   Mx_ACK = routed slave ACK (combinational, same cycle).
//  Unmapped: no slave strobe. Mx_ERR=1 on the cycle after STB is seen, for exactly 1 cycle.
//   The strobe is not re-errored until STB drops or ADR changes.
//  Read data: Mx_DATR = DAT of the decoded slave while owned; 0 otherwise.
//  CYC dropped mid-STB: slave STB falls the same cycle. The FSM goes to IDLE and no ACK is
//   forwarded.
//  Async Reset mid-transfer: all strobes and grants drop immediately. The FSM is in IDLE at
//   the first edge after release.
// CONFIGURATION
//  WB_TIMEOUT_EN defined: a counter runs while STB_slave=1 and ACK=0 and clears on ACK or
//   STB low. At count==TIMEOUT the slave STB is forced low, Mx_ERR pulses 1 cycle and the
//   counter clears. The grant is kept.
//  WB_TIMEOUT_EN undefined: no counter. A missing ACK stalls the owner indefinitely.
// STRUCTURE
//  wb_pkg: state enum {IDLE,OWN0,OWN1}, slave-select enum {SEL_NONE,SEL_UART,SEL_TMR},
//   address-map constants (UART_BASE, TMR_BASE, TMR_LAST), TIMEOUT default.
//  Sub-module wb_addr_decode: pure combinational ADR -> slave select. It is reused by
//   future bridges.
// TESTING
//  1 M0 read at ADR=5'b01000, ACK_TMR after 2 cycles, DAT_TMR=8'hA5
//    -> STB_TMR=1 for 3 cycles, M0_ACK=1 with M0_DATR=8'hA5.
//  2 M0_CYC and M1_CYC rise together from reset -> M0 granted. After M0 drops CYC: one IDLE
//    cycle, then M1_GNT=1. Rise together again -> M0 granted (round-robin).
//  3 M1 owns and does back-to-back strobes to ADR=5'b00001 (UART); M0 raises CYC
//    -> M0_GNT stays 0 until M1_CYC=0. M1 gets no turnaround between its own strobes.
//  4 M0 write to ADR=5'b11010 -> STB_UART=STB_TMR=0, M0_ERR=1 for exactly 1 cycle.
//  5 WB_TIMEOUT_EN, TIMEOUT=15, TMR never ACKs -> STB_TMR drops and M0_ERR=1 on cycle 15.
//    Without the macro, STB_TMR stays 1 for 100 cycles with no ERR.
//  6 Reset pulsed while STB_UART=1 -> STB_UART=0 and GNT=0 asynchronously, state IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and address map for the peripheral Wishbone arbiter and its decoder.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_UART = 2'd1,
    SEL_TMR  = 2'd2
  } sel_t;

  // Region codes taken from the top two word-address bits
  localparam logic [1:0] UART_BASE = 2'b00;
  localparam logic [1:0] TMR_BASE  = 2'b01;
  localparam logic [1:0] TMR_LAST  = 2'b10;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/wb_addr_decode.sv
// Pure combinational word address -> slave select; shared with future bridges.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] adr,
  output sel_t          sel
);

  logic [1:0] region;
  logic       unused_low;

  assign region     = adr[AW-1 -: 2];
  assign unused_low = ^adr[AW-3:0];

  // Map the region code onto a slave select
  always_comb begin
    sel = SEL_NONE;
    if (region == UART_BASE)
      sel = SEL_UART;
    else if ((region >= TMR_BASE) && (region <= TMR_LAST))
      sel = SEL_TMR;
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin arbiter and slave decoder for the peripheral Wishbone bus.
// Optional feature: define WB_TIMEOUT_EN to abort a strobe that waits TIMEOUT cycles
// for an ACK (slave strobe forced low, one-cycle ERR to the owner, grant kept).
module wb_bus_arbiter
  import wb_pkg::*;
#(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          PClk,
  input  logic          Reset,
  input  logic          M0_CYC,
  input  logic          M0_STB,
  input  logic          M0_WE,
  input  logic [AW-1:0] M0_ADR,
  input  logic [DW-1:0] M0_DATW,
  output logic          M0_ACK,
  output logic          M0_ERR,
  output logic [DW-1:0] M0_DATR,
  output logic          M0_GNT,
  input  logic          M1_CYC,
  input  logic          M1_STB,
  input  logic          M1_WE,
  input  logic [AW-1:0] M1_ADR,
  input  logic [DW-1:0] M1_DATW,
  output logic          M1_ACK,
  output logic          M1_ERR,
  output logic [DW-1:0] M1_DATR,
  output logic          M1_GNT,
  output logic [AW-1:0] ADR,
  output logic [DW-1:0] DAT,
  output logic          WE,
  output logic          STB_UART,
  output logic          STB_TMR,
  input  logic          ACK_UART,
  input  logic          ACK_TMR,
  input  logic [DW-1:0] DAT_UART,
  input  logic [DW-1:0] DAT_TMR
);

  state_t        state;
  logic          last;       // 1: M1 owned most recently, so M0 wins the next tie
  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;
  sel_t          sel;
  logic          live, unmapped, ack_c, tmo_hit;
  logic [DW-1:0] datr;
  logic          err0_r, err1_r, err_blk, err_fire;
  logic [AW-1:0] err_adr;

  // Route the current owner's request onto the shared bus; idle bus is all zero
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    case (state)
      OWN0: begin
        own_cyc = M0_CYC;
        own_stb = M0_STB;
        own_we  = M0_WE;
        own_adr = M0_ADR;
        own_dat = M0_DATW;
      end
      OWN1: begin
        own_cyc = M1_CYC;
        own_stb = M1_STB;
        own_we  = M1_WE;
        own_adr = M1_ADR;
        own_dat = M1_DATW;
      end
      default: ;
    endcase
  end

  wb_addr_decode #(.AW(AW)) u_dec (
    .adr (own_adr),
    .sel (sel)
  );

  assign ADR = own_adr;
  assign DAT = own_dat;
  assign WE  = own_we;

  // A timed-out strobe is suppressed for the cycle the error is reported
  assign live     = own_cyc & own_stb & ~tmo_hit;
  assign STB_UART = live & (sel == SEL_UART);
  assign STB_TMR  = live & (sel == SEL_TMR);
  assign unmapped = live & (sel == SEL_NONE);
  assign ack_c    = (STB_UART & ACK_UART) | (STB_TMR & ACK_TMR);

  // Read data follows the decoded slave
  always_comb begin
    datr = '0;
    case (sel)
      SEL_UART: datr = DAT_UART;
      SEL_TMR:  datr = DAT_TMR;
      default:  datr = '0;
    endcase
  end

  assign M0_GNT  = (state == OWN0);
  assign M1_GNT  = (state == OWN1);
  assign M0_ACK  = M0_GNT & ack_c;
  assign M1_ACK  = M1_GNT & ack_c;
  assign M0_DATR = M0_GNT ? datr : '0;
  assign M1_DATR = M1_GNT ? datr : '0;
  assign M0_ERR  = err0_r | (tmo_hit & M0_GNT);
  assign M1_ERR  = err1_r | (tmo_hit & M1_GNT);

  // Ownership FSM: grant from IDLE only, hold for the whole CYC, always return via IDLE
  always_ff @(posedge PClk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (M0_CYC && M1_CYC) begin
            state <= last ? OWN0 : OWN1;
            last  <= ~last;
          end else if (M0_CYC) begin
            state <= OWN0;
            last  <= 1'b0;
          end else if (M1_CYC) begin
            state <= OWN1;
            last  <= 1'b1;
          end
        end
        OWN0:    if (!M0_CYC) state <= IDLE;
        OWN1:    if (!M1_CYC) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One error pulse per unmapped strobe; re-arm only when STB drops or ADR moves
  assign err_fire = unmapped & ~(err_blk & (own_adr == err_adr));

  // Error pulse and re-arm tracking
  always_ff @(posedge PClk or posedge Reset) begin
    if (Reset) begin
      err0_r  <= 1'b0;
      err1_r  <= 1'b0;
      err_blk <= 1'b0;
    end else begin
      err0_r  <= err_fire & (state == OWN0);
      err1_r  <= err_fire & (state == OWN1);
      err_blk <= unmapped;
    end
  end

  // Address of the last unmapped strobe, only meaningful while err_blk is set
  always_ff @(posedge PClk) begin
    err_adr <= own_adr;
  end

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT));

  // Count cycles a mapped strobe waits for its ACK
  always_ff @(posedge PClk or posedge Reset) begin
    if (Reset)
      tmo_cnt <= '0;
    else if (tmo_hit)
      tmo_cnt <= '0;
    else if ((STB_UART | STB_TMR) & ~ack_c)
      tmo_cnt <= tmo_cnt + CW'(1);
    else
      tmo_cnt <= '0;
  end
`else
  localparam int unused_tmo = TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios followed by random traffic,
// all cycles compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_wb_bus_arbiter;
  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int TMO = 15;

  logic          PClk = 1'b0;
  logic          Reset;
  logic          M0_CYC, M0_STB, M0_WE, M1_CYC, M1_STB, M1_WE;
  logic [AW-1:0] M0_ADR, M1_ADR;
  logic [DW-1:0] M0_DATW, M1_DATW;
  logic          M0_ACK, M0_ERR, M0_GNT, M1_ACK, M1_ERR, M1_GNT;
  logic [DW-1:0] M0_DATR, M1_DATR;
  logic [AW-1:0] ADR;
  logic [DW-1:0] DAT;
  logic          WE, STB_UART, STB_TMR, ACK_UART, ACK_TMR;
  logic [DW-1:0] DAT_UART, DAT_TMR;

  wb_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .PClk(PClk), .Reset(Reset),
    .M0_CYC(M0_CYC), .M0_STB(M0_STB), .M0_WE(M0_WE), .M0_ADR(M0_ADR), .M0_DATW(M0_DATW),
    .M0_ACK(M0_ACK), .M0_ERR(M0_ERR), .M0_DATR(M0_DATR), .M0_GNT(M0_GNT),
    .M1_CYC(M1_CYC), .M1_STB(M1_STB), .M1_WE(M1_WE), .M1_ADR(M1_ADR), .M1_DATW(M1_DATW),
    .M1_ACK(M1_ACK), .M1_ERR(M1_ERR), .M1_DATR(M1_DATR), .M1_GNT(M1_GNT),
    .ADR(ADR), .DAT(DAT), .WE(WE), .STB_UART(STB_UART), .STB_TMR(STB_TMR),
    .ACK_UART(ACK_UART), .ACK_TMR(ACK_TMR), .DAT_UART(DAT_UART), .DAT_TMR(DAT_TMR)
  );

  always #5 PClk = ~PClk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, who owned last, pending error pulses, wait count
  int m_own;      // 0 idle, 1 M0, 2 M1
  int m_last;     // index of the most recent owner
  int m_cnt;
  bit m_blk;
  int m_blkadr;
  bit m_errp0, m_errp1;

  // Expected bus values for the current cycle
  int e_adr, e_dat, e_we, e_rd;
  bit e_su, e_st, e_ack, e_unm, e_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 1; m_cnt = 0; m_blk = 0; m_blkadr = 0;
    m_errp0 = 0; m_errp1 = 0;
  endtask

  task automatic eval_model();
    bit cyc, stb;
    int region;
    e_adr = 0; e_dat = 0; e_we = 0; cyc = 0; stb = 0;
    if (m_own == 1) begin
      e_adr = int'(M0_ADR); e_dat = int'(M0_DATW); e_we = int'(M0_WE);
      cyc = M0_CYC; stb = M0_STB;
    end else if (m_own == 2) begin
      e_adr = int'(M1_ADR); e_dat = int'(M1_DATW); e_we = int'(M1_WE);
      cyc = M1_CYC; stb = M1_STB;
    end
    region = e_adr / 8;
`ifdef WB_TIMEOUT_EN
    e_hit = (m_cnt == TMO);
`else
    e_hit = 1'b0;
`endif
    e_su  = cyc && stb && !e_hit && (region == 0);
    e_st  = cyc && stb && !e_hit && (region == 1 || region == 2);
    e_unm = cyc && stb && !e_hit && (region == 3);
    e_ack = (e_su && ACK_UART) || (e_st && ACK_TMR);
    if (m_own == 0 || region == 3) e_rd = 0;
    else if (region == 0)          e_rd = int'(DAT_UART);
    else                           e_rd = int'(DAT_TMR);
  endtask

  task automatic model_edge();
    bit fire;
    eval_model();
    fire    = e_unm && !(m_blk && m_blkadr == e_adr);
    m_errp0 = fire && (m_own == 1);
    m_errp1 = fire && (m_own == 2);
    m_blk   = e_unm;
    m_blkadr = e_adr;
`ifdef WB_TIMEOUT_EN
    if (m_cnt == TMO)                   m_cnt = 0;
    else if ((e_su || e_st) && !e_ack)  m_cnt = m_cnt + 1;
    else                                m_cnt = 0;
`endif
    if (m_own == 0) begin
      if (M0_CYC && M1_CYC) m_own = (m_last == 1) ? 1 : 2;
      else if (M0_CYC)      m_own = 1;
      else if (M1_CYC)      m_own = 2;
    end else begin
      m_last = m_own - 1;
      if (!((m_own == 1) ? M0_CYC : M1_CYC)) m_own = 0;
    end
  endtask

  task automatic check_all(input string tag);
    eval_model();
    chk({tag, " gnt0"}, 32'(M0_GNT), 32'(m_own == 1));
    chk({tag, " gnt1"}, 32'(M1_GNT), 32'(m_own == 2));
    chk({tag, " adr"},  32'(ADR), e_adr);
    chk({tag, " dat"},  32'(DAT), e_dat);
    chk({tag, " we"},   32'(WE), e_we);
    chk({tag, " stb_uart"}, 32'(STB_UART), 32'(e_su));
    chk({tag, " stb_tmr"},  32'(STB_TMR), 32'(e_st));
    chk({tag, " ack0"}, 32'(M0_ACK), 32'(e_ack && m_own == 1));
    chk({tag, " ack1"}, 32'(M1_ACK), 32'(e_ack && m_own == 2));
    chk({tag, " err0"}, 32'(M0_ERR), 32'(m_errp0 || (e_hit && m_own == 1)));
    chk({tag, " err1"}, 32'(M1_ERR), 32'(m_errp1 || (e_hit && m_own == 2)));
    chk({tag, " datr0"}, 32'(M0_DATR), (m_own == 1) ? e_rd : 0);
    chk({tag, " datr1"}, 32'(M1_DATR), (m_own == 2) ? e_rd : 0);
  endtask

  task automatic sample(input string tag);
    #2;
    check_all(tag);
  endtask

  task automatic edge_step();
    @(posedge PClk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    edge_step();
  endtask

  task automatic idle_masters();
    M0_CYC = 0; M0_STB = 0; M0_WE = 0; M0_ADR = '0; M0_DATW = '0;
    M1_CYC = 0; M1_STB = 0; M1_WE = 0; M1_ADR = '0; M1_DATW = '0;
  endtask

  initial begin
    int stb_hi, err_n;
    Reset = 1'b1;
    idle_masters();
    ACK_UART = 0; ACK_TMR = 0; DAT_UART = 8'h3C; DAT_TMR = 8'h00;
    model_reset();
    repeat (2) @(posedge PClk);
    #1;
    sample("reset");
    chk("reset gnt0", 32'(M0_GNT), 32'd0);
    chk("reset adr", 32'(ADR), 32'd0);
    Reset = 1'b0;

    // Simultaneous request from reset: M0 first, turnaround, M1, then M0 again
    M0_CYC = 1; M1_CYC = 1;
    step("t2 req");
    sample("t2 own0");
    chk("t2 m0 first", 32'(M0_GNT), 32'd1);
    M0_CYC = 0;
    edge_step();
    sample("t2 turn");
    chk("t2 turnaround", 32'(M0_GNT | M1_GNT), 32'd0);
    edge_step();
    sample("t2 own1");
    chk("t2 m1 next", 32'(M1_GNT), 32'd1);
    M1_CYC = 0;
    step("t2 drop1");
    M0_CYC = 1; M1_CYC = 1;
    step("t2 req2");
    sample("t2 rr");
    chk("t2 m0 again", 32'(M0_GNT), 32'd1);
    idle_masters();
    step("t2 end");

    // M0 timer read, ACK on the third strobe cycle
    M0_CYC = 1; M0_STB = 1; M0_ADR = 5'b01000; DAT_TMR = 8'hA5;
    step("t1 req");
    stb_hi = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ACK_TMR = 1;
      sample("t1 xfer");
      stb_hi += int'(STB_TMR);
      if (i == 2) begin
        chk("t1 ack", 32'(M0_ACK), 32'd1);
        chk("t1 datr", 32'(M0_DATR), 32'hA5);
      end
      edge_step();
    end
    chk("t1 stb cycles", stb_hi, 3);
    idle_masters(); ACK_TMR = 0;
    step("t1 end");

    // M1 holds the bus through back-to-back UART strobes while M0 waits
    M1_CYC = 1; M1_STB = 1; M1_ADR = 5'b00001; ACK_UART = 1;
    step("t3 req");
    M0_CYC = 1; M0_STB = 1; M0_ADR = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      M1_DATW = 8'(i + 1);
      sample("t3 hold");
      chk("t3 m0 waits", 32'(M0_GNT), 32'd0);
      chk("t3 m1 ack", 32'(M1_ACK), 32'd1);
      edge_step();
    end
    M1_CYC = 0; M1_STB = 0;
    step("t3 drop");
    sample("t3 turn");
    chk("t3 turnaround", 32'(M0_GNT), 32'd0);
    edge_step();
    sample("t3 m0");
    chk("t3 m0 granted", 32'(M0_GNT), 32'd1);
    idle_masters(); ACK_UART = 0;
    edge_step();
    step("t3 end");

    // Unmapped write: no slave strobe, a single ERR pulse
    M0_CYC = 1; M0_STB = 1; M0_WE = 1; M0_ADR = 5'b11010; M0_DATW = 8'h5A;
    step("t4 req");
    err_n = 0;
    for (int i = 0; i < 5; i++) begin
      sample("t4 unm");
      err_n += int'(M0_ERR);
      chk("t4 no strobe", 32'(STB_UART | STB_TMR), 32'd0);
      edge_step();
    end
    chk("t4 err pulses", err_n, 1);
    idle_masters();
    step("t4 end");

    // Timer never acknowledges
    M0_CYC = 1; M0_STB = 1; M0_ADR = 5'b01000;
    step("t5 req");
    stb_hi = 0; err_n = 0;
`ifdef WB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      sample("t5 tmo");
      stb_hi += int'(STB_TMR);
      err_n  += int'(M0_ERR);
      edge_step();
    end
    chk("t5 stb cycles", stb_hi, TMO);
    chk("t5 err pulses", err_n, 1);
`else
    for (int i = 0; i < 100; i++) begin
      sample("t5 stall");
      stb_hi += int'(STB_TMR);
      err_n  += int'(M0_ERR);
      edge_step();
    end
    chk("t5 stb cycles", stb_hi, 100);
    chk("t5 err pulses", err_n, 0);
`endif
    idle_masters();
    step("t5 end");

    // Asynchronous reset in the middle of a UART strobe
    M0_CYC = 1; M0_STB = 1; M0_ADR = 5'b00011;
    step("t6 req");
    sample("t6 live");
    chk("t6 uart live", 32'(STB_UART), 32'd1);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("t6 rst");
    chk("t6 stb drop", 32'(STB_UART), 32'd0);
    chk("t6 gnt drop", 32'(M0_GNT), 32'd0);
    idle_masters();
    @(posedge PClk);
    #1;
    Reset = 1'b0;
    step("t6 rel");
    sample("t6 idle");

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if (M0_CYC) begin
        if ($urandom_range(9) == 0) begin M0_CYC = 0; M0_STB = 0; end
        else M0_STB = 1'($urandom_range(1));
      end else if ($urandom_range(3) == 0) M0_CYC = 1;
      if (M1_CYC) begin
        if ($urandom_range(9) == 0) begin M1_CYC = 0; M1_STB = 0; end
        else M1_STB = 1'($urandom_range(1));
      end else if ($urandom_range(3) == 0) M1_CYC = 1;
      if ($urandom_range(2) == 0) M0_ADR = AW'($urandom);
      if ($urandom_range(2) == 0) M1_ADR = AW'($urandom);
      M0_WE = 1'($urandom); M1_WE = 1'($urandom);
      M0_DATW = DW'($urandom); M1_DATW = DW'($urandom);
      ACK_UART = 1'($urandom); ACK_TMR = 1'($urandom);
      DAT_UART = DW'($urandom); DAT_TMR = DW'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
